// File: rtl/alu_op_issuer.sv
// Sequential initiator for the 32-bit gate-level ALU: accepts one op, holds operands for a settle window, returns result.
// Optional zero flag on the response is enabled by defining ALU_ISSUER_ZERO_FLAG_EN.
module alu_op_issuer #(
  parameter int unsigned ARITH_SETTLE = 8,
  parameter int unsigned LOGIC_SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  alu_cmd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_cout,
  input  logic        alu_ovf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_res,
  output logic        resp_cout,
  output logic        resp_ovf,
  output logic        resp_zero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [7:0] ARITH_INIT = 8'(ARITH_SETTLE - 1);
  localparam logic [7:0] LOGIC_INIT = 8'(LOGIC_SETTLE - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       is_arith;
  logic       capture;

  // ADD, SUB and SLT go through the carry chain and need the longer window
  always_comb begin
    is_arith = 1'b0;
    case (req_cmd)
      3'd0, 3'd1, 3'd3: is_arith = 1'b1;
      default:          is_arith = 1'b0;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign capture   = (state == SETTLE) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_cmd    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_cout  <= 1'b0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_cmd <= req_cmd;
            alu_a   <= req_a;
            alu_b   <= req_b;
            cnt     <= is_arith ? ARITH_INIT : LOGIC_INIT;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (capture) begin
            resp_res   <= alu_res;
            resp_cout  <= alu_cout;
            resp_ovf   <= alu_ovf;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUER_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_zero <= 1'b0;
    end else if (capture) begin
      resp_zero <= ~|alu_res;
    end
  end
`else
  assign resp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: behavioural ALU model on the alu_* side, expected responses queued at accept.
module tb_alu_op_issuer;

  localparam int unsigned ARITH_N = 8;
  localparam int unsigned LOGIC_N = 2;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cout, alu_ovf;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_res;
  logic        resp_cout, resp_ovf, resp_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  alu_op_issuer #(.ARITH_SETTLE(ARITH_N), .LOGIC_SETTLE(LOGIC_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res(resp_res), .resp_cout(resp_cout), .resp_ovf(resp_ovf), .resp_zero(resp_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t alu_ref(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    s = '0;
    case (cmd)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1, 3'd3: begin
        s      = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.cout = s[32];
        e.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
        e.res  = (cmd == 3'd1) ? s[31:0] : {31'b0, s[31] ^ e.ovf};
      end
      3'd2:    e.res = a ^ b;
      3'd4:    e.res = a & b;
      3'd5:    e.res = ~(a & b);
      3'd6:    e.res = ~(a | b);
      default: e.res = a | b;
    endcase
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    e.zero = (e.res == 32'd0);
`else
    e.zero = 1'b0;
`endif
    return e;
  endfunction

  always_comb begin
    exp_t r;
    r        = alu_ref(alu_cmd, alu_a, alu_b);
    alu_res  = r.res;
    alu_cout = r.cout;
    alu_ovf  = r.ovf;
  end

  function automatic int settle_of(input logic [2:0] cmd);
    return (cmd == 3'd0 || cmd == 3'd1 || cmd == 3'd3) ? ARITH_N : LOGIC_N;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_res", resp_res, 32'd0);
    check("rst_resp_cout", {31'b0, resp_cout}, 32'd0);
    check("rst_resp_ovf", {31'b0, resp_ovf}, 32'd0);
    check("rst_resp_zero", {31'b0, resp_zero}, 32'd0);
    check("rst_alu_cmd", {29'b0, alu_cmd}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input bit early_ready, input int bp, input bit hold_valid);
    exp_t e;
    int   j;
    req_cmd = cmd; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b0;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    sb.push_back(alu_ref(cmd, a, b));
    if (hold_valid) begin
      req_cmd = cmd ^ 3'd1; req_a = ~a; req_b = ~b;
    end else begin
      req_valid = 1'b0;
    end
    if (early_ready) resp_ready = 1'b1;
    j = 0;
    while (!resp_valid && j < 300) begin
      check("settle_alu_cmd", {29'b0, alu_cmd}, {29'b0, cmd});
      check("settle_alu_a", alu_a, a);
      check("settle_alu_b", alu_b, b);
      check("settle_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      j++;
    end
    check("latency", 32'(j), 32'(settle_of(cmd)));
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("resp_res", resp_res, e.res);
    check("resp_cout", {31'b0, resp_cout}, {31'b0, e.cout});
    check("resp_ovf", {31'b0, resp_ovf}, {31'b0, e.ovf});
    check("resp_zero", {31'b0, resp_zero}, {31'b0, e.zero});
    if (bp > 0) resp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_resp_res", resp_res, e.res);
      check("bp_resp_flags", {29'b0, resp_cout, resp_ovf, resp_zero}, {29'b0, e.cout, e.ovf, e.zero});
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_alu_cmd", {29'b0, alu_cmd}, {29'b0, cmd});
      check("bp_alu_a", alu_a, a);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 32'd5, 32'd3, 1'b1, 0, 1'b0);                  // ADD 5+3
    do_op(3'd1, 32'd7, 32'd7, 1'b0, 0, 1'b0);                  // SUB 7-7
    do_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 0, 1'b0);  // AND
    do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, 1'b0);          // ADD overflow
    do_op(3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 5, 1'b1);  // backpressure, req_valid held
    do_op(3'd3, 32'hFFFF_FFFE, 32'd1, 1'b0, 0, 1'b0);          // SLT -2 < 1
    do_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);  // NAND -> 0
    do_op(3'd6, 32'h0000_00FF, 32'h0F00_0000, 1'b1, 0, 1'b0);  // NOR
    do_op(3'd7, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 2, 1'b0);  // OR
    for (int k = 0; k < 4; k++)
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);

    // Reset in the middle of an ADD settle window
    req_cmd = 3'd0; req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
    end
    do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);         // ADD carryout, zero result

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
